miriscv_prefetch_fetch_unit: RTL and testbench
==============================================

Name: miriscv_prefetch_fetch_unit

Overview:
Parametrised next-generation instruction fetch stage for the miriscv core. It decouples the pipeline from instruction memory latency. It keeps up to MAX_OUTSTANDING requests in flight on a req/gnt/rvalid bus and buffers returned words with their PCs in a FETCH_DEPTH prefetch FIFO. It sits between instruction memory and decode and handles stall, kill (branch redirect) and boot-address load.

Parameters:
XLEN, 32, data and address width; must be 32 (RV32).
FETCH_DEPTH, 2, prefetch FIFO entries (instr + PC); power of two, at least 1.
MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests; at least 1.
NOP_INSTR, 32'h00000013, instruction driven on instr_o when no valid entry is available.

Ports:
clk_i  in  1  clock; all state updates on its rising edge
arstn_i  in  1  reset, asynchronous, active-low
boot_addr_i  in  XLEN  address loaded when cu_boot_addr_load_en_i is high
instr_req_o  out  1  memory request
instr_gnt_i  in  1  memory accepts the request this cycle
instr_addr_o  out  XLEN  request address, word aligned
instr_rvalid_i  in  1  response valid; responses return in order
instr_rdata_i  in  XLEN  response data
cu_pc_bra_i  in  XLEN  redirect target
cu_stall_f_i  in  1  pipeline does not consume this cycle
cu_kill_f_i  in  1  flush and redirect to cu_pc_bra_i
cu_boot_addr_load_en_i  in  1  flush and redirect to boot_addr_i
instr_o  out  XLEN  FIFO head instruction, or NOP_INSTR when empty
fetched_pc_addr_o  out  XLEN  head PC, 0 when empty
fetched_pc_next_addr_o  out  XLEN  head PC + 4, modulo 2^XLEN
fetch_rvalid_o  out  1  FIFO non-empty

Behaviour:
- Reset values: pc_reg=0, FIFO empty, outstanding=0, discard=0, fetch_rvalid_o=0, instr_o=NOP_INSTR, fetched_pc_*=0.
- Fetch address: instr_addr_o=pc_reg.
  - instr_req_o = !kill & !boot_load & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding - discard < FETCH_DEPTH).
  - Credit rule: every non-discarded response always has a FIFO slot.
- Grant is a handshake on instr_req_o & instr_gnt_i:
  - pc_reg += 4, wrapping at 2^XLEN.
  - Push pc_reg into the pending-PC queue (depth MAX_OUTSTANDING).
  - outstanding++.
- With req high and gnt low, instr_addr_o holds stable. instr_req_o may drop without gnt only for kill/boot or a lost credit.
- Response, instr_rvalid_i:
  - Pop the pending-PC queue; outstanding--.
  - If discard>0, drop the response and discard--.
  - Otherwise push {pc, rdata} into the FIFO.
- Minimum latency: memory response in cycle N gives fetch_rvalid_o=1 in cycle N+1.
- Consume: pop the FIFO head when fetch_rvalid_o & !cu_stall_f_i.
  - While stalled, the head and all fetched_* outputs hold.
  - Push and pop in the same cycle keep the count unchanged.
- Kill (cu_kill_f_i=1):
  - pc_reg <= cu_pc_bra_i; the FIFO is emptied at the next edge.
  - discard <= outstanding - instr_rvalid_i, counting responses still pending after this cycle.
  - A response arriving this cycle is dropped.
  - fetch_rvalid_o=0 next cycle.
  - Kill wins over stall.
- Boot load: identical to kill but with target boot_addr_i. It has priority over kill.
- Redirect targets are word aligned; bits [1:0] are forced to 0.
- Back-to-back kills: discard accumulates only from the live outstanding count and never exceeds MAX_OUTSTANDING.
- Reset mid-operation clears all state immediately. Responses to requests issued before reset are a memory-side responsibility and need no handling here.
- Assertions:
  - No rvalid while outstanding=0.
  - No FIFO overflow or underflow.
  - discard ≤ outstanding.

Test Plan:
1. Reset, boot_addr_i=0x100 loaded for 1 cycle, memory gnt=1 with 1-cycle latency, no stall -> instr_addr_o 0x100,0x104,...; fetch_rvalid_o rises 2 cycles after first gnt; consecutive fetched_pc_addr_o 0x100,0x104,0x108 with next=+4.
2. After FIFO fills, hold cu_stall_f_i 6 cycles -> head holds; instr_req_o drops once fifo_count+outstanding=FETCH_DEPTH; on release entries drain in PC order with no duplicate or lost PC.
3. Kill with target 0x200 while 2 requests are outstanding (latency 3) -> both late responses dropped; next fetch_rvalid_o=1 shows PC 0x200 with its data; instr_o=0x13 in the gap.
4. gnt held low 4 cycles with req high -> instr_addr_o constant; pc_reg does not advance; no response is expected.
5. Kill and boot load in the same cycle, then kill during stall -> boot_addr_i wins; kill overrides stall; FIFO is empty next cycle.
6. pc_reg=0xFFFFFFFC fetched -> next request address 0x00000000; fetched_pc_next_addr_o=0; async reset asserted mid-stream clears fetch_rvalid_o without waiting for a clock edge.

Source files
------------

// File: rtl/miriscv_prefetch_fetch_unit.sv
// ---------------------------------------------------------------------------
// miriscv_prefetch_fetch_unit
//   Prefetching instruction fetch stage. Keeps up to MAX_OUTSTANDING requests
//   in flight on a req/gnt/rvalid memory bus and buffers the returned words,
//   tagged with their PCs, in a FETCH_DEPTH-entry FIFO that feeds decode.
//   Handles pipeline stall, kill (branch redirect) and boot-address load.
//
// Ports
//   clk_i, arstn_i              clock, async active-low reset
//   boot_addr_i                 redirect target for cu_boot_addr_load_en_i
//   instr_req_o/gnt_i/addr_o    memory request channel (addr = pc_reg)
//   instr_rvalid_i/rdata_i      in-order memory responses
//   cu_pc_bra_i                 redirect target for cu_kill_f_i
//   cu_stall_f_i                decode does not consume this cycle
//   cu_kill_f_i                 flush + redirect to cu_pc_bra_i
//   cu_boot_addr_load_en_i      flush + redirect to boot_addr_i (wins over kill)
//   instr_o, fetched_pc_*_o     FIFO head (NOP / 0 when empty)
//   fetch_rvalid_o              FIFO non-empty
// ---------------------------------------------------------------------------

// Small synchronous queue: push/pop in any combination, optional flush.
module miriscv_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 wdata_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q;

  // Explicit wrap so DEPTH need not fill the pointer range.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
      else if (!push_i && pop_i) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
endmodule

module miriscv_prefetch_fetch_unit #(
  parameter int          XLEN            = 32,
  parameter int          FETCH_DEPTH     = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic [XLEN-1:0] boot_addr_i,
  output logic            instr_req_o,
  input  logic            instr_gnt_i,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic [XLEN-1:0] cu_pc_bra_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_boot_addr_load_en_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] fetched_pc_addr_o,
  output logic [XLEN-1:0] fetched_pc_next_addr_o,
  output logic            fetch_rvalid_o
);
  localparam int CW = $clog2(FETCH_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   discard_q, discard_d;

  logic            redirect, grant;
  logic [XLEN-1:0] redirect_pc;
  logic [SW-1:0]   slots_used;

  logic            fifo_push, fifo_pop;
  logic [CW-1:0]   fifo_cnt;
  fetch_entry_t    fifo_wdata, fifo_head;
  logic [XLEN-1:0] pend_pc;
  logic [OW-1:0]   pend_cnt;

  assign redirect    = cu_boot_addr_load_en_i | cu_kill_f_i;
  // Boot load beats kill; targets are forced word aligned.
  assign redirect_pc = (cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i) & ~XLEN'(3);

  // Slots already promised: buffered entries plus live (non-discarded)
  // requests. Requesting only below FETCH_DEPTH guarantees every kept
  // response a FIFO slot, so rvalid never needs back-pressure.
  assign slots_used  = SW'(fifo_cnt) + SW'(outst_q) - SW'(discard_q);
  assign instr_req_o = !redirect && (outst_q < OW'(MAX_OUTSTANDING)) &&
                       (slots_used < SW'(FETCH_DEPTH));
  assign instr_addr_o = pc_q;
  assign grant        = instr_req_o & instr_gnt_i;

  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    outst_d   = outst_q + OW'(grant) - OW'(instr_rvalid_i);
    if (redirect)   pc_d = redirect_pc;
    else if (grant) pc_d = pc_q + XLEN'(4);
    // On redirect every response still pending after this cycle is stale;
    // re-deriving from the live count keeps back-to-back kills bounded.
    if (redirect)
      discard_d = outst_q - OW'(instr_rvalid_i);
    else if (instr_rvalid_i && discard_q != '0)
      discard_d = discard_q - OW'(1);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pc_q      <= '0;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  // PCs of granted requests, consumed in order as responses return
  // (including ones that are dropped).
  miriscv_fetch_queue #(.DEPTH(MAX_OUTSTANDING), .W(XLEN)) u_pend_q (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (1'b0),
    .push_i  (grant),
    .wdata_i (pc_q),
    .pop_i   (instr_rvalid_i),
    .rdata_o (pend_pc),
    .count_o (pend_cnt)
  );

  assign fifo_push  = instr_rvalid_i && (discard_q == '0) && !redirect;
  assign fifo_pop   = fetch_rvalid_o && !cu_stall_f_i && !redirect;
  assign fifo_wdata = '{pc: pend_pc, instr: instr_rdata_i};

  miriscv_fetch_queue #(.DEPTH(FETCH_DEPTH), .W(2*XLEN)) u_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt)
  );

  assign fetch_rvalid_o         = (fifo_cnt != '0);
  assign instr_o                = fetch_rvalid_o ? fifo_head.instr : NOP_INSTR;
  assign fetched_pc_addr_o      = fetch_rvalid_o ? fifo_head.pc : '0;
  assign fetched_pc_next_addr_o = fetch_rvalid_o ? fifo_head.pc + XLEN'(4) : '0;

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!arstn_i)
    instr_rvalid_i |-> (outst_q != '0));
  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
    (fifo_push && !fifo_pop) |-> (fifo_cnt < CW'(FETCH_DEPTH)));
  a_fifo_no_underflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
    fifo_pop |-> (fifo_cnt != '0));
  a_discard_bound: assert property (@(posedge clk_i) disable iff (!arstn_i)
    discard_q <= outst_q);
  a_pend_tracks: assert property (@(posedge clk_i) disable iff (!arstn_i)
    pend_cnt == outst_q);
endmodule

// File: tb/tb_miriscv_prefetch_fetch_unit.sv
module tb_miriscv_prefetch_fetch_unit;
  logic        clk = 1'b0;
  logic        arstn_i;
  logic [31:0] boot_addr_i, cu_pc_bra_i;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        cu_stall_f_i, cu_kill_f_i, cu_boot_addr_load_en_i;
  logic [31:0] instr_o, fetched_pc_addr_o, fetched_pc_next_addr_o;
  logic        fetch_rvalid_o;

  always #5 clk = ~clk;

  miriscv_prefetch_fetch_unit dut (
    .clk_i                  (clk),
    .arstn_i                (arstn_i),
    .boot_addr_i            (boot_addr_i),
    .instr_req_o            (instr_req_o),
    .instr_gnt_i            (instr_gnt_i),
    .instr_addr_o           (instr_addr_o),
    .instr_rvalid_i         (instr_rvalid_i),
    .instr_rdata_i          (instr_rdata_i),
    .cu_pc_bra_i            (cu_pc_bra_i),
    .cu_stall_f_i           (cu_stall_f_i),
    .cu_kill_f_i            (cu_kill_f_i),
    .cu_boot_addr_load_en_i (cu_boot_addr_load_en_i),
    .instr_o                (instr_o),
    .fetched_pc_addr_o      (fetched_pc_addr_o),
    .fetched_pc_next_addr_o (fetched_pc_next_addr_o),
    .fetch_rvalid_o         (fetch_rvalid_o)
  );

  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int cyc = 0, lat = 1;
  logic gnt_en = 1'b0;
  bit mon_en = 1'b0;

  assign instr_gnt_i = gnt_en;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic seq(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4*i));
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) nxt();
  endtask

  // Memory: in-order responses, 'lat' cycles after the grant cycle.
  initial begin
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mreq_t m;
        m = mq.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = memf(m.addr);
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
      end
    end
  end

  always @(negedge clk)
    if (arstn_i && instr_req_o && instr_gnt_i)
      mq.push_back('{addr: instr_addr_o, due: cyc + lat});

  // Scoreboard monitor: every consumed head must be the next expected PC.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fetch_rvalid_o) begin
        if (!cu_stall_f_i && !cu_kill_f_i && !cu_boot_addr_load_en_i) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underrun: consumed pc %h with nothing expected", fetched_pc_addr_o);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", fetched_pc_addr_o, e);
            chk("sb_instr", instr_o, memf(e));
            chk("sb_next", fetched_pc_next_addr_o, e + 32'd4);
          end
        end
      end else begin
        chk("idle_instr", instr_o, 32'h00000013);
        chk("idle_pc", fetched_pc_addr_o, 32'h0);
        chk("idle_next", fetched_pc_next_addr_o, 32'h0);
      end
    end
  end

  initial begin
    bit found;
    arstn_i = 1'b0; boot_addr_i = '0; cu_pc_bra_i = '0;
    cu_stall_f_i = 1'b0; cu_kill_f_i = 1'b0; cu_boot_addr_load_en_i = 1'b0;
    #2;
    chk("rst_rvalid", 32'(fetch_rvalid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h00000013);
    chk("rst_pc", fetched_pc_addr_o, 32'h0);
    chk("rst_next", fetched_pc_next_addr_o, 32'h0);
    chk("rst_addr", instr_addr_o, 32'h0);
    nxt();
    arstn_i = 1'b1; mon_en = 1'b1;

    // 1: boot load to 0x100, gnt=1, latency 1
    nxt();
    cu_boot_addr_load_en_i = 1'b1; boot_addr_i = 32'h100; gnt_en = 1'b1; seq(32'h100);
    @(negedge clk); chk("boot_req_low", 32'(instr_req_o), 32'h0);
    nxt(); cu_boot_addr_load_en_i = 1'b0;
    @(negedge clk); chk("t1_req", 32'(instr_req_o), 32'h1); chk("t1_addr0", instr_addr_o, 32'h100);
    nxt();
    @(negedge clk); chk("t1_addr1", instr_addr_o, 32'h104); chk("t1_rv_early", 32'(fetch_rvalid_o), 32'h0);
    nxt();
    @(negedge clk); chk("t1_rv_rise", 32'(fetch_rvalid_o), 32'h1);
    chk("t1_pc", fetched_pc_addr_o, 32'h100); chk("t1_next", fetched_pc_next_addr_o, 32'h104);
    nxt();
    run(10);

    // 2: stall 6 cycles
    cu_stall_f_i = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      if (s >= 3) begin
        chk("stall_rvalid", 32'(fetch_rvalid_o), 32'h1);
        chk("stall_req_low", 32'(instr_req_o), 32'h0);
        chk("stall_head", fetched_pc_addr_o, exp_q[0]);
        chk("stall_next", fetched_pc_next_addr_o, exp_q[0] + 32'd4);
      end
      nxt();
    end
    cu_stall_f_i = 1'b0;
    run(8);

    // 3: kill to 0x200 with two requests outstanding at latency 3
    gnt_en = 1'b0;
    run(6);
    @(negedge clk); chk("drained", 32'(fetch_rvalid_o), 32'h0);
    nxt(); lat = 3; gnt_en = 1'b1;
    @(negedge clk); chk("g0_req", 32'(instr_req_o), 32'h1);
    nxt();
    @(negedge clk); chk("g1_req", 32'(instr_req_o), 32'h1);
    nxt(); cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'h200; seq(32'h200);
    @(negedge clk); chk("kill_req_low", 32'(instr_req_o), 32'h0);
    nxt(); cu_kill_f_i = 1'b0;
    @(negedge clk); chk("g3_rvalid", 32'(fetch_rvalid_o), 32'h0);
    chk("g3_nop", instr_o, 32'h00000013); chk("g3_req", 32'(instr_req_o), 32'h0);
    nxt();
    @(negedge clk); chk("g4_req", 32'(instr_req_o), 32'h1); chk("g4_addr", instr_addr_o, 32'h200);
    nxt();
    @(negedge clk); chk("g5_req", 32'(instr_req_o), 32'h1); chk("g5_addr", instr_addr_o, 32'h204);
    nxt();
    @(negedge clk); chk("g6_req", 32'(instr_req_o), 32'h0);
    nxt();
    @(negedge clk); chk("g7_rvalid", 32'(fetch_rvalid_o), 32'h0); chk("g7_nop", instr_o, 32'h00000013);
    nxt();
    @(negedge clk); chk("g8_rvalid", 32'(fetch_rvalid_o), 32'h1);
    chk("g8_pc", fetched_pc_addr_o, 32'h200); chk("g8_instr", instr_o, 32'hDEAD0200);
    nxt();
    run(4);

    // 4: gnt held low with req high
    gnt_en = 1'b0;
    run(6);
    cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'h300; seq(32'h300);
    nxt(); cu_kill_f_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("nogn_req", 32'(instr_req_o), 32'h1);
      chk("nogn_addr", instr_addr_o, 32'h300);
      chk("nogn_rvalid", 32'(fetch_rvalid_o), 32'h0);
      nxt();
    end
    gnt_en = 1'b1;
    run(14);

    // 5: boot+kill same cycle, then kill during stall
    cu_boot_addr_load_en_i = 1'b1; boot_addr_i = 32'h400;
    cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'h500; seq(32'h400);
    @(negedge clk); chk("bk_req_low", 32'(instr_req_o), 32'h0);
    nxt(); cu_boot_addr_load_en_i = 1'b0; cu_kill_f_i = 1'b0;
    @(negedge clk); chk("bk_addr", instr_addr_o, 32'h400); chk("bk_rvalid", 32'(fetch_rvalid_o), 32'h0);
    nxt();
    run(14);
    cu_stall_f_i = 1'b1;
    run(2);
    cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'h602; seq(32'h600);
    nxt(); cu_kill_f_i = 1'b0;
    @(negedge clk); chk("ks_rvalid", 32'(fetch_rvalid_o), 32'h0); chk("ks_addr", instr_addr_o, 32'h600);
    nxt(); cu_stall_f_i = 1'b0;
    run(14);

    // 6: address wrap, then async reset mid-stream
    lat = 1;
    cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'hFFFFFFF8; seq(32'hFFFFFFF8);
    nxt(); cu_kill_f_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (fetch_rvalid_o && fetched_pc_addr_o == 32'hFFFFFFFC) begin
        chk("wrap_next", fetched_pc_next_addr_o, 32'h0);
        found = 1'b1;
      end
      nxt();
    end
    if (!found) begin
      n_chk++;
      $display("FAIL wrap_timeout: pc FFFFFFFC never presented, got %h", fetched_pc_addr_o);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (fetch_rvalid_o) found = 1'b1;
      else nxt();
    end
    if (!found) begin
      n_chk++;
      $display("FAIL arst_setup_timeout: fetch_rvalid_o stayed %0d, required 1", fetch_rvalid_o);
    end
    mon_en = 1'b0;
    #2 arstn_i = 1'b0;
    mq.delete();
    #1;
    chk("arst_rvalid", 32'(fetch_rvalid_o), 32'h0);
    chk("arst_instr", instr_o, 32'h00000013);
    chk("arst_pc", fetched_pc_addr_o, 32'h0);
    chk("arst_next", fetched_pc_next_addr_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
